// File: rtl/conv_filter_engine_if.sv
// Avalon-MM slave bus bundle for conv_filter_engine.
// The CPU/DMAC side uses the master modport and the engine uses the slave modport.
interface conv_filter_engine_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/conv_filter_engine.sv
// conv_filter_engine: single-pixel KSIZE x KSIZE grayscale convolution engine
// on an Avalon-MM slave. The host loads window pixels and kernel coefficients,
// then starts a run. The engine accumulates one tap per cycle, then shifts,
// optionally takes the absolute value, and clamps the sum into one result pixel.
// Optional feature macro: FILTER_IRQ_EN adds the irq output and CTRL[2] irq_en.
//
// state   | meaning
// IDLE    | registers accessible, waiting for a start trigger
// COMPUTE | one multiply-accumulate per cycle, idx 0..NUM_TAPS-1
// FINISH  | shift/abs/clamp the accumulator into result, set done
module conv_filter_engine #(
    parameter int BIT_PER_PIXEL = 8,
    parameter int KSIZE         = 3,
    parameter int COEF_W        = 5,
    parameter int ADDR_W        = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_filter_engine_if.slave    bus
`ifdef FILTER_IRQ_EN
    ,
    output logic                   irq
`endif
);
    localparam int B        = BIT_PER_PIXEL;
    localparam int NUM_TAPS = KSIZE * KSIZE;
    localparam int IDX_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int ACC_W    = B + COEF_W + $clog2(NUM_TAPS) + 1;

    localparam logic [ADDR_W-1:0] A_NT     = ADDR_W'(NUM_TAPS);
    localparam logic [ADDR_W-1:0] A_COEF   = ADDR_W'(32);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(64);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(65);
    localparam logic [ADDR_W-1:0] A_RESULT = ADDR_W'(66);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_TAPS - 1);
    localparam logic signed [COEF_W-1:0] CENTRE_COEF = COEF_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [B-1:0]               result_q, result_d;
    logic                       done_q, done_d;
    logic                       abs_en_q, abs_en_d;
    logic                       auto_q, auto_d;
    logic [3:0]                 shift_q, shift_d;
    logic                       irq_en_q, irq_en_d;
    logic                       irq_q, irq_d;
    logic [3*B-1:0]             pix_q [NUM_TAPS];
    logic [3*B-1:0]             pix_d [NUM_TAPS];
    logic signed [COEF_W-1:0]   coef_q [NUM_TAPS];
    logic signed [COEF_W-1:0]   coef_d [NUM_TAPS];

    logic                       busy, is_pix, is_coef, is_ctrl, rd_only, start_trig, wr_ok;
    logic [ADDR_W-1:0]          coef_off;
    logic [IDX_W-1:0]           a_idx;
    logic [B-1:0]               gray, res_clamped;
    logic [COEF_W-1:0]          coef_sel;
    logic signed [ACC_W-1:0]    prod, v;
    logic                       unused_wdata;

    assign busy     = (state_q != IDLE);
    assign is_pix   = (bus.address < A_NT);
    assign is_coef  = (bus.address >= A_COEF) && (bus.address < A_COEF + A_NT);
    assign is_ctrl  = (bus.address == A_CTRL);
    assign coef_off = bus.address - A_COEF;
    assign a_idx    = is_pix ? bus.address[IDX_W-1:0] : coef_off[IDX_W-1:0];
    assign rd_only  = bus.read && !bus.write;
    assign coef_sel = coef_q[a_idx];
    assign unused_wdata = ^bus.writedata;

    // Stall RESULT reads and register writes while a run is in flight.
    assign bus.waitrequest = busy && ((rd_only && bus.address == A_RESULT) ||
                                      (bus.write && (is_pix || is_coef || is_ctrl)));
    assign wr_ok      = bus.write && !bus.waitrequest;
    assign start_trig = (state_q == IDLE) && bus.write &&
                        ((is_ctrl && bus.writedata[0]) ||
                         (bus.address == A_NT - ADDR_W'(1) && auto_q));

    // Tap datapath: grayscale the current pixel and multiply by its signed coefficient.
    always_comb begin
        gray = B'((77 * 32'(pix_q[idx_q][B-1:0]) + 150 * 32'(pix_q[idx_q][2*B-1:B]) +
                   29 * 32'(pix_q[idx_q][3*B-1:2*B])) >> 8);
        prod = $signed({{(ACC_W-B){1'b0}}, gray}) *
               $signed({{(ACC_W-COEF_W){coef_q[idx_q][COEF_W-1]}}, coef_q[idx_q]});
        v = acc_q >>> shift_q;
        if (abs_en_q && v[ACC_W-1]) v = -v;
        if (v[ACC_W-1])              res_clamped = '0;
        else if (|v[ACC_W-2:B])      res_clamped = '1;
        else                         res_clamped = v[B-1:0];
    end

    // Next-state logic for the sequencer, register file writes and done/irq flags.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = done_q;
        abs_en_d = abs_en_q;
        auto_d   = auto_q;
        shift_d  = shift_q;
        irq_en_d = irq_en_q;
        pix_d    = pix_q;
        coef_d   = coef_q;
        case (state_q)
            IDLE: begin
                if (start_trig) begin
                    state_d = COMPUTE;
                    idx_d   = '0;
                    acc_d   = '0;
                    done_d  = 1'b0;
                end
            end
            COMPUTE: begin
                acc_d = acc_q + prod;
                if (idx_q == LAST_IDX) state_d = FINISH;
                else                   idx_d   = idx_q + IDX_W'(1);
            end
            FINISH: begin
                result_d = res_clamped;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (wr_ok) begin
            if (is_pix)  pix_d[a_idx]  = bus.writedata[3*B-1:0];
            if (is_coef) coef_d[a_idx] = bus.writedata[COEF_W-1:0];
            if (is_ctrl) begin
                abs_en_d = bus.writedata[1];
`ifdef FILTER_IRQ_EN
                irq_en_d = bus.writedata[2];
`endif
                auto_d   = bus.writedata[3];
                shift_d  = bus.writedata[7:4];
            end
        end
        if (rd_only && bus.address == A_RESULT && !bus.waitrequest) done_d = 1'b0;
`ifdef FILTER_IRQ_EN
        irq_d = done_d && irq_en_d;
`else
        irq_d = 1'b0;
`endif
    end

    // Combinational read mux; simultaneous read+write is treated as a write.
    always_comb begin
        bus.readdata = '0;
        if (rd_only) begin
            if (is_pix)                          bus.readdata = 32'(pix_q[a_idx]);
            else if (is_coef)                    bus.readdata = {{(32-COEF_W){coef_sel[COEF_W-1]}}, coef_sel};
            else if (bus.address == A_CTRL)      bus.readdata = {24'd0, shift_q, auto_q, irq_en_q, abs_en_q, 1'b0};
            else if (bus.address == A_STATUS)    bus.readdata = {30'd0, done_q, busy};
            else if (bus.address == A_RESULT)    bus.readdata = 32'(result_q);
        end
    end

    // State and register-file storage, async reset to the edge-detect kernel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            abs_en_q <= 1'b0;
            auto_q   <= 1'b0;
            shift_q  <= '0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                pix_q[i]  <= '0;
                coef_q[i] <= (i == NUM_TAPS / 2) ? CENTRE_COEF : '1;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
            abs_en_q <= abs_en_d;
            auto_q   <= auto_d;
            shift_q  <= shift_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
            pix_q    <= pix_d;
            coef_q   <= coef_d;
        end
    end

`ifdef FILTER_IRQ_EN
    assign irq = irq_q;
`endif
endmodule

// File: tb/tb_conv_filter_engine.sv
// Directed bench for conv_filter_engine (default 3x3, 8-bit, 5-bit coefficients).
module tb_conv_filter_engine;
    localparam int LIMIT = 64;
    localparam logic [6:0] A_CTRL = 7'h40, A_STATUS = 7'h41, A_RESULT = 7'h42;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
`ifdef FILTER_IRQ_EN
    logic irq;
`endif

    conv_filter_engine_if #(.ADDR_W(7)) bif ();

    conv_filter_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
`ifdef FILTER_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [6:0] a, input logic [31:0] d, output int waits);
        waits = 0;
        bif.address = a; bif.writedata = d; bif.write = 1'b1;
        @(negedge clk);
        while (bif.waitrequest && waits < LIMIT) begin waits++; @(negedge clk); end
        if (waits >= LIMIT) begin errors++; $display("FAIL write_timeout addr=%0h", a); end
        @(posedge clk); #1;
        bif.write = 1'b0;
    endtask

    task automatic bus_read(input logic [6:0] a, output logic [31:0] d, output int waits);
        waits = 0;
        bif.address = a; bif.read = 1'b1;
        @(negedge clk);
        while (bif.waitrequest && waits < LIMIT) begin waits++; @(negedge clk); end
        if (waits >= LIMIT) begin errors++; $display("FAIL read_timeout addr=%0h", a); end
        d = bif.readdata;
        @(posedge clk); #1;
        bif.read = 1'b0;
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        int w;
        bus_write(a, d, w);
    endtask

    task automatic rd_check(input string tag, input logic [6:0] a, input logic [31:0] exp);
        logic [31:0] d; int w;
        bus_read(a, d, w);
        check(tag, d, exp);
    endtask

    // Poll STATUS until idle; returns number of busy polls and the final STATUS.
    task automatic wait_idle(output int busy_n, output logic [31:0] st);
        int w;
        busy_n = 0;
        bus_read(A_STATUS, st, w);
        while (st[0] && busy_n < LIMIT) begin busy_n++; bus_read(A_STATUS, st, w); end
        if (busy_n >= LIMIT) begin errors++; $display("FAIL idle_timeout busy=%0d", busy_n); end
    endtask

    task automatic load_window(input logic [31:0] centre, input logic [31:0] other);
        for (int i = 0; i < 9; i++) wr(7'(i), (i == 4) ? centre : other);
    endtask

    initial begin
        logic [31:0] st, d;
        int          n, w;
        clk = 1'b0; reset = 1'b1;
        bif.address = '0; bif.read = 1'b0; bif.write = 1'b0; bif.writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_waitrequest", {31'd0, bif.waitrequest}, 32'd0);
        check("rst_readdata", bif.readdata, 32'd0);
        reset = 1'b0;

        rd_check("rst_status", A_STATUS, 32'h0);
        rd_check("rst_result", A_RESULT, 32'h0);
        rd_check("rst_ctrl", A_CTRL, 32'h0);
        rd_check("rst_pix0", 7'h00, 32'h0);
        rd_check("rst_coef4", 7'h24, 32'h8);
        rd_check("rst_coef0", 7'h20, 32'hFFFF_FFFF);
        wr(7'h50, 32'h1234);
        bus_read(7'h50, d, w);
        check("unmapped_read", d, 32'h0);
        check("unmapped_nostall", w, 0);

        // read and write together act as a write with readdata 0
        bif.address = 7'h00; bif.writedata = 32'h11; bif.read = 1'b1; bif.write = 1'b1;
        @(negedge clk);
        check("rw_readdata", bif.readdata, 32'h0);
        @(posedge clk); #1;
        bif.read = 1'b0; bif.write = 1'b0;
        rd_check("rw_pix0", 7'h00, 32'h11);

        // 1: flat 100 window with edge kernel sums to zero
        load_window(32'h646464, 32'h646464);
        wr(A_CTRL, 32'h01);
        wait_idle(n, st);
        check("t1_busy_cycles", n, 10);
        check("t1_status", st, 32'h2);
        rd_check("t1_result", A_RESULT, 32'h0);
        rd_check("t1_status_after", A_STATUS, 32'h0);

        // 2: centre 200, others 0 -> 1600 clamps, >>3 gives 200
        load_window(32'hC8C8C8, 32'h0);
        wr(A_CTRL, 32'h01);
        wait_idle(n, st);
        rd_check("t2_clamp_hi", A_RESULT, 32'd255);
        wr(A_CTRL, 32'h31);
        wait_idle(n, st);
        rd_check("t2_shift3", A_RESULT, 32'd200);
        rd_check("t2_ctrl_readback", A_CTRL, 32'h30);

        // 3: centre 0, others 50 -> -400
        load_window(32'h0, 32'h323232);
        wr(A_CTRL, 32'h01);
        wait_idle(n, st);
        rd_check("t3_clamp_lo", A_RESULT, 32'd0);
        wr(A_CTRL, 32'h13);
        wait_idle(n, st);
        rd_check("t3_abs_shift1", A_RESULT, 32'd200);

        // 4: RESULT read right after start stalls for the whole run
        wr(A_CTRL, 32'h11);
        bus_read(A_RESULT, d, w);
        check("t4_stall_cycles", w, 10);
        check("t4_readdata", d, 32'd0);
        rd_check("t4_done_cleared", A_STATUS, 32'h0);

        // 5: auto_start on last pixel write; coef write during busy stalls then lands
        wr(A_CTRL, 32'h38);
        load_window(32'hC8C8C8, 32'h0);
        bus_write(7'h20, 32'h3, w);
        check("t5_coef_stall", w, 10);
        rd_check("t5_status", A_STATUS, 32'h2);
        rd_check("t5_coef0", 7'h20, 32'h3);
        rd_check("t5_result", A_RESULT, 32'd200);

        // 6: reset in the middle of COMPUTE
        wr(7'h24, 32'h5);
        rd_check("t6_coef4_pre", 7'h24, 32'h5);
        wr(A_CTRL, 32'h01);
        bif.address = A_RESULT; bif.read = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t6_stalled", {31'd0, bif.waitrequest}, 32'd1);
        reset = 1'b1;
        #1;
        check("t6_released", {31'd0, bif.waitrequest}, 32'd0);
        check("t6_rd_result", bif.readdata, 32'd0);
        bif.read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        rd_check("t6_status", A_STATUS, 32'h0);
        rd_check("t6_coef4", 7'h24, 32'h8);
        rd_check("t6_result", A_RESULT, 32'h0);
        rd_check("t6_ctrl", A_CTRL, 32'h0);
`ifdef FILTER_IRQ_EN
        wr(A_CTRL, 32'h05);
        wait_idle(n, st);
        check("t6_irq_set", {31'd0, irq}, 32'd1);
        rd_check("t6_ctrl_irq_en", A_CTRL, 32'h4);
        rd_check("t6_irq_result", A_RESULT, 32'd0);
        check("t6_irq_clear", {31'd0, irq}, 32'd0);
`else
        wr(A_CTRL, 32'h04);
        rd_check("t6_irq_en_ignored", A_CTRL, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
